// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings and constants for the pong match logic.
// Contents: FSM state codes, winner codes, ball centre coordinates, default winning score.
package pong_pkg;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_RALLY = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;
   typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10} winner_t;
   localparam int CENTER_X = 316;
   localparam int CENTER_Y = 236;
   localparam int DEFAULT_WIN_SCORE = 9;
endpackage

// File: rtl/match_sequencer_if.sv
// match_sequencer_if: event inputs and match-status outputs of the rally sequencer.
// Inputs to the sequencer: frame_tick, start, point_p1, point_p2, paddle_hit.
// Outputs from the sequencer: ball_run, ball_center, serve_right, score1, score2, winner, speed_level, state.
// slave = sequencer side, master = driver/observer side.
interface match_sequencer_if;
   logic       frame_tick;
   logic       start;
   logic       point_p1;
   logic       point_p2;
   logic       paddle_hit;
   logic       ball_run;
   logic       ball_center;
   logic       serve_right;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] winner;
   logic [2:0] speed_level;
   logic [2:0] state;
   modport slave (
      input  frame_tick, start, point_p1, point_p2, paddle_hit,
      output ball_run, ball_center, serve_right, score1, score2, winner, speed_level, state
   );
   modport master (
      output frame_tick, start, point_p1, point_p2, paddle_hit,
      input  ball_run, ball_center, serve_right, score1, score2, winner, speed_level, state
   );
endinterface

// File: rtl/tick_countdown.sv
// tick_countdown: counts frame ticks down from a loaded value and flags the final one.
// Ports: clk, reset (sync, active-high), load strobe, load_value, frame_tick in; done out.
// done is combinational so the owner can change state on the very edge of the qualifying tick.
// A tick coinciding with load is not counted because load takes priority.
module tick_countdown #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         frame_tick,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= load_value;
      else if (frame_tick && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign done = frame_tick && cnt == W'(1);
endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: pong match flow FSM with scores, winner decode and rally speed escalation.
// Ports: clk, reset (sync, active-high); bus (slave) carries frame_tick/start/point/hit inputs
// and the registered ball_run, ball_center, serve_right, score1/2, winner, speed_level, state outputs.
module match_sequencer
   import pong_pkg::*;
#(
   parameter int WIN_SCORE      = DEFAULT_WIN_SCORE,
   parameter int SERVE_DELAY    = 60,
   parameter int POINT_DELAY    = 90,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MAX_LEVEL      = 7
) (
   input logic clk,
   input logic reset,
   match_sequencer_if.slave bus
);
   localparam logic [3:0] WIN_LAST = 4'(WIN_SCORE - 1);
   localparam logic [7:0] HIT_LAST = 8'(HITS_PER_LEVEL - 1);
   localparam logic [2:0] LVL_MAX  = 3'(MAX_LEVEL);
   logic       load, done;
   logic [7:0] load_value;
   logic [7:0] hits;
   // The countdown is reloaded on every entry into SERVE or POINT; RALLY is the only
   // state that loads the point pause, every other load is a serve delay.
   assign load = (bus.state == S_IDLE && bus.start) || (bus.state == S_POINT && done) ||
                 (bus.state == S_RALLY && (bus.point_p1 || bus.point_p2));
   assign load_value = bus.state == S_RALLY ? 8'(POINT_DELAY) : 8'(SERVE_DELAY);
   tick_countdown #(.W(8)) u_countdown (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_value(load_value),
      .frame_tick(bus.frame_tick),
      .done(done)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.state       <= S_IDLE;
         bus.ball_run    <= 1'b0;
         bus.ball_center <= 1'b0;
         bus.serve_right <= 1'b0;
         bus.score1      <= '0;
         bus.score2      <= '0;
         bus.winner      <= WIN_NONE;
         bus.speed_level <= '0;
         hits            <= '0;
      end else begin
         bus.ball_center <= 1'b0;
         case (bus.state)
            S_IDLE: if (bus.start) begin
               bus.state       <= S_SERVE;
               bus.ball_center <= 1'b1;
            end
            S_SERVE: if (done) begin
               bus.state    <= S_RALLY;
               bus.ball_run <= 1'b1;
            end
            // Priority: point_p1 over point_p2, any point over paddle_hit.
            S_RALLY: if (bus.point_p1) begin
               bus.score1      <= bus.score1 + 1'b1;
               bus.serve_right <= 1'b1;
               bus.ball_run    <= 1'b0;
               bus.state       <= bus.score1 == WIN_LAST ? S_OVER : S_POINT;
               bus.winner      <= bus.score1 == WIN_LAST ? WIN_P1 : WIN_NONE;
            end else if (bus.point_p2) begin
               bus.score2      <= bus.score2 + 1'b1;
               bus.serve_right <= 1'b0;
               bus.ball_run    <= 1'b0;
               bus.state       <= bus.score2 == WIN_LAST ? S_OVER : S_POINT;
               bus.winner      <= bus.score2 == WIN_LAST ? WIN_P2 : WIN_NONE;
            end else if (bus.paddle_hit) begin
               hits            <= hits == HIT_LAST ? '0 : hits + 1'b1;
               bus.speed_level <= hits == HIT_LAST && bus.speed_level != LVL_MAX ?
                                  bus.speed_level + 1'b1 : bus.speed_level;
            end
            S_POINT: if (done) begin
               bus.state       <= S_SERVE;
               bus.ball_center <= 1'b1;
               bus.speed_level <= '0;
               hits            <= '0;
            end
            S_OVER: ;
            default: bus.state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed vector table plus hand-written match sequences for match_sequencer.
module tb_match_sequencer;
   import pong_pkg::*;
   typedef struct packed {
      logic       rst, st, tk, p1, p2, hit;
      logic [2:0] es;
      logic       er, ec, esr;
      logic [3:0] e1, e2;
      logic [1:0] ew;
      logic [2:0] el;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl [29];
   match_sequencer_if bus();
   match_sequencer #(
      .WIN_SCORE(9), .SERVE_DELAY(3), .POINT_DELAY(2), .HITS_PER_LEVEL(4), .MAX_LEVEL(7)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic idle_inputs();
      reset = 1'b0;
      bus.start = 1'b0;
      bus.frame_tick = 1'b0;
      bus.point_p1 = 1'b0;
      bus.point_p2 = 1'b0;
      bus.paddle_hit = 1'b0;
   endtask
   task automatic check_all(input string tag, input int es, input int er, input int ec, input int esr,
                            input int e1, input int e2, input int ew, input int el);
      chk({tag, ".state"}, int'(bus.state), es);
      chk({tag, ".ball_run"}, int'(bus.ball_run), er);
      chk({tag, ".ball_center"}, int'(bus.ball_center), ec);
      chk({tag, ".serve_right"}, int'(bus.serve_right), esr);
      chk({tag, ".score1"}, int'(bus.score1), e1);
      chk({tag, ".score2"}, int'(bus.score2), e2);
      chk({tag, ".winner"}, int'(bus.winner), ew);
      chk({tag, ".speed_level"}, int'(bus.speed_level), el);
   endtask
   task automatic tick_until(input logic [2:0] target);
      for (int n = 0; n < 50 && bus.state != target; n++) begin
         bus.frame_tick = 1'b1;
         step();
      end
      bus.frame_tick = 1'b0;
      chk("reach_state", int'(bus.state), int'(target));
   endtask
   task automatic score_point(input logic two);
      bus.point_p1 = !two;
      bus.point_p2 = two;
      step();
      bus.point_p1 = 1'b0;
      bus.point_p2 = 1'b0;
   endtask
   initial begin
      //          rst st tk p1 p2 hit  st run ctr sr s1 s2 w lvl
      tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 1, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 1};
      tbl[12] = '{0, 0, 1, 0, 0, 0,   2, 1, 0, 0, 0, 0, 0, 1};
      tbl[13] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 1};
      tbl[14] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 1};
      tbl[15] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 1};
      tbl[16] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 2};
      tbl[17] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 2};
      tbl[18] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 2};
      tbl[19] = '{0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0, 2};
      tbl[20] = '{0, 0, 0, 1, 1, 1,   3, 0, 0, 1, 1, 0, 0, 2};
      tbl[21] = '{0, 0, 0, 0, 1, 1,   3, 0, 0, 1, 1, 0, 0, 2};
      tbl[22] = '{0, 0, 1, 0, 0, 0,   3, 0, 0, 1, 1, 0, 0, 2};
      tbl[23] = '{0, 0, 1, 0, 0, 0,   1, 0, 1, 1, 1, 0, 0, 0};
      tbl[24] = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0};
      tbl[25] = '{0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0};
      tbl[26] = '{0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0};
      tbl[27] = '{0, 0, 1, 0, 0, 0,   2, 1, 0, 1, 1, 0, 0, 0};
      tbl[28] = '{0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 1, 1, 0, 0};
      idle_inputs();
      for (int i = 0; i < 29; i++) begin
         reset = tbl[i].rst;
         bus.start = tbl[i].st;
         bus.frame_tick = tbl[i].tk;
         bus.point_p1 = tbl[i].p1;
         bus.point_p2 = tbl[i].p2;
         bus.paddle_hit = tbl[i].hit;
         step();
         check_all($sformatf("vec%0d", i), int'(tbl[i].es), int'(tbl[i].er), int'(tbl[i].ec),
                   int'(tbl[i].esr), int'(tbl[i].e1), int'(tbl[i].e2), int'(tbl[i].ew), int'(tbl[i].el));
      end
      idle_inputs();
      // speed saturation: 36 hits would be 9 levels unclamped
      tick_until(S_RALLY);
      bus.paddle_hit = 1'b1;
      repeat (36) step();
      bus.paddle_hit = 1'b0;
      chk("sat.speed_level", int'(bus.speed_level), 7);
      // drive score2 from 1 to 8, then the winning point
      for (int k = 0; k < 7; k++) begin
         score_point(1'b1);
         tick_until(S_RALLY);
      end
      chk("pre_win.score2", int'(bus.score2), 8);
      score_point(1'b1);
      check_all("win", 4, 0, 0, 0, 1, 9, 2, 0);
      bus.start = 1'b1;
      bus.point_p1 = 1'b1;
      bus.frame_tick = 1'b1;
      bus.paddle_hit = 1'b1;
      repeat (5) step();
      idle_inputs();
      check_all("over_hold", 4, 0, 0, 0, 1, 9, 2, 0);
      // reset from a live rally at 3/5 with a raised speed level
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tick_until(S_RALLY);
      for (int k = 0; k < 8; k++) begin
         score_point(k >= 3);
         tick_until(S_RALLY);
      end
      bus.paddle_hit = 1'b1;
      repeat (4) step();
      bus.paddle_hit = 1'b0;
      check_all("pre_reset", 2, 1, 0, 0, 3, 5, 0, 1);
      reset = 1'b1;
      step();
      check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step();
      chk("post_reset.state", int'(bus.state), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
